// File: rtl/usbf_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the USB function core slave port.
// A stall watchdog terminates accesses the core never acknowledges.
module usbf_wb_arbiter #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  // master 0
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_data_i,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic [31:0]       m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  // master 1
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_data_i,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic [31:0]       m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  // slave
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [31:0]       s_data_o,
  output logic              s_we_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic [31:0]       s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT0  = 3'd1,
    GNT1  = 3'd2,
    TERM0 = 3'd3,
    TERM1 = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic             stall;
  logic             wd_hit;

  // Slave-side mux and ack routing from the current owner.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign m0_err_o  = err0_q;
  assign m1_err_o  = err1_q;
  assign gnt_o     = {(state_q == GNT1) || (state_q == TERM1),
                      (state_q == GNT0) || (state_q == TERM0)};

  assign stall  = s_stb_o & ~s_ack_i;
  assign wd_hit = stall && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next state, grant history, watchdog count and error pulses.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i)   state_d = m1_cyc_i ? GNT1 : IDLE;
        else if (wd_hit) state_d = TERM0;
      end
      GNT1: begin
        if (!m1_cyc_i)   state_d = m0_cyc_i ? GNT0 : IDLE;
        else if (wd_hit) state_d = TERM1;
      end
      TERM0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      TERM1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
    if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;

    // Count only consecutive stalls within one ownership period.
    if (state_d == state_q && stall) cnt_d = cnt_q + CNT_W'(1);

    err0_d = (state_d == TERM0) && (state_q != TERM0);
    err1_d = (state_d == TERM1) && (state_q != TERM1);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

endmodule

// File: tb/tb_usbf_wb_arbiter.sv
// Scoreboard bench for usbf_wb_arbiter: expected responses are queued as accesses
// are driven and compared when an ack or err appears on a master port.
module tb_usbf_wb_arbiter;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr_o;
  logic [31:0]       m0_data, m1_data, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic              m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic              m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic              s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0]        gnt_o;

  typedef struct packed {
    logic [1:0]  m;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    passed = 0;

  usbf_wb_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_we_i(m0_we), .m0_stb_i(m0_stb),
    .m0_cyc_i(m0_cyc), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_we_i(m1_we), .m1_stb_i(m1_stb),
    .m1_cyc_i(m1_cyc), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_data = data;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_data = data;
    end
  endtask

  function automatic logic err_of(input int m);
    return (m == 0) ? m0_err_o : m1_err_o;
  endfunction

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  // Response currently presented on the master ports.
  function automatic resp_t obs_now();
    resp_t r;
    r.m    = {m1_ack_o | m1_err_o, m0_ack_o | m0_err_o};
    r.err  = m0_err_o | m1_err_o;
    r.data = m0_ack_o ? m0_data_o : (m1_ack_o ? m1_data_o : 32'h0);
    return r;
  endfunction

  function automatic resp_t sb_pop();
    if (sb.size() == 0) return '1;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 9'h0)
      $display("FAIL reset_ctl: got %h expected %h",
               {gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 9'h0);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_addr_o, s_data_o, gnt_o} !== 52'h0)
      $display("FAIL reset_bus: got %h expected %h", {s_addr_o, s_data_o, gnt_o}, 52'h0);
    else passed++;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_simultaneous();
    resp_t e, o;
    for (int r = 0; r < 2; r++) begin
      tick();
      drive_m(0, 1, 1, 0, 18'h20010, 32'h0);
      drive_m(1, 1, 1, 0, 18'h00020, 32'h0);
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00) $display("FAIL sim_req_gnt: got %b expected %b", gnt_o, 2'b00);
      else passed++;
      tick();
      s_ack_i = 1'b1; s_data_i = 32'h1111_0000 + 32'(r);
      sb.push_back('{m: 2'b01, err: 1'b0, data: s_data_i});
      @(negedge clk);
      checks++;
      if ({gnt_o, s_addr_o} !== {2'b01, 18'h20010})
        $display("FAIL sim_first_gnt: got %h expected %h", {gnt_o, s_addr_o}, {2'b01, 18'h20010});
      else passed++;
      o = obs_now(); e = sb_pop();
      checks++;
      if (o !== e) $display("FAIL sim_m0_resp: got %h expected %h", o, e);
      else passed++;
      tick();
      s_ack_i = 1'b0;
      drive_m(0, 0, 0, 0, 18'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({gnt_o, m1_ack_o} !== {2'b01, 1'b0})
        $display("FAIL sim_hold_gnt: got %h expected %h", {gnt_o, m1_ack_o}, {2'b01, 1'b0});
      else passed++;
      tick();
      s_ack_i = 1'b1; s_data_i = 32'h2222_0000 + 32'(r);
      sb.push_back('{m: 2'b10, err: 1'b0, data: s_data_i});
      @(negedge clk);
      checks++;
      if ({gnt_o, s_stb_o, s_addr_o} !== {2'b10, 1'b1, 18'h00020})
        $display("FAIL sim_handover: got %h expected %h", {gnt_o, s_stb_o, s_addr_o}, {2'b10, 1'b1, 18'h00020});
      else passed++;
      o = obs_now(); e = sb_pop();
      checks++;
      if (o !== e) $display("FAIL sim_m1_resp: got %h expected %h", o, e);
      else passed++;
      tick();
      s_ack_i = 1'b0;
      drive_m(1, 0, 0, 0, 18'h0, 32'h0);
      tick();
      @(negedge clk);
      checks++;
      if (gnt_o !== 2'b00) $display("FAIL sim_idle: got %b expected %b", gnt_o, 2'b00);
      else passed++;
    end
  endtask

  task automatic test_single_write();
    resp_t e, o;
    tick();
    drive_m(0, 1, 1, 1, 18'h20004, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) $display("FAIL sw_req_gnt: got %b expected %b", gnt_o, 2'b00);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m0_ack_o, m1_ack_o} !==
        {2'b01, 3'b111, 18'h20004, 32'h0, 2'b00})
      $display("FAIL sw_mirror: got %h expected %h",
               {gnt_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, m0_ack_o, m1_ack_o},
               {2'b01, 3'b111, 18'h20004, 32'h0, 2'b00});
    else passed++;
    for (int k = 1; k < 3; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if (m0_ack_o !== 1'b0) $display("FAIL sw_early_ack: got %b expected %b", m0_ack_o, 1'b0);
      else passed++;
    end
    tick();
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_0001;
    sb.push_back('{m: 2'b01, err: 1'b0, data: s_data_i});
    @(negedge clk);
    o = obs_now(); e = sb_pop();
    checks++;
    if (o !== e) $display("FAIL sw_resp: got %h expected %h", o, e);
    else passed++;
    checks++;
    if (m1_data_o !== 32'hDEAD_0001) $display("FAIL sw_broadcast: got %h expected %h", m1_data_o, 32'hDEAD_0001);
    else passed++;
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 18'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({gnt_o, m0_ack_o} !== {2'b01, 1'b0})
      $display("FAIL sw_release: got %h expected %h", {gnt_o, m0_ack_o}, {2'b01, 1'b0});
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) $display("FAIL sw_idle: got %b expected %b", gnt_o, 2'b00);
    else passed++;
  endtask

  task automatic test_no_preempt();
    resp_t e, o;
    tick();
    drive_m(1, 1, 1, 1, 18'h00040, 32'hC0DE_0000);
    @(negedge clk);
    tick();
    drive_m(0, 1, 1, 0, 18'h20020, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive_m(1, 1, 1, 1, 18'h00040 + 18'(4 * k), 32'hC0DE_0000 + 32'(k));
      s_ack_i = 1'b1; s_data_i = 32'hB000_0000 + 32'(k);
      sb.push_back('{m: 2'b10, err: 1'b0, data: s_data_i});
      @(negedge clk);
      checks++;
      if ({gnt_o, s_addr_o, s_data_o} !== {2'b10, 18'h00040 + 18'(4 * k), 32'hC0DE_0000 + 32'(k)})
        $display("FAIL np_beat_mux: got %h expected %h", {gnt_o, s_addr_o, s_data_o},
                 {2'b10, 18'h00040 + 18'(4 * k), 32'hC0DE_0000 + 32'(k)});
      else passed++;
      o = obs_now(); e = sb_pop();
      checks++;
      if (o !== e) $display("FAIL np_beat_resp: got %h expected %h", o, e);
      else passed++;
      tick();
      s_ack_i = 1'b0;
      drive_m(1, 1, 0, 1, 18'h00040, 32'h0);
      @(negedge clk);
      checks++;
      if ({gnt_o, m0_ack_o} !== {2'b10, 1'b0})
        $display("FAIL np_gap: got %h expected %h", {gnt_o, m0_ack_o}, {2'b10, 1'b0});
      else passed++;
      tick();
    end
    drive_m(1, 0, 0, 0, 18'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({gnt_o, m0_ack_o} !== {2'b10, 1'b0})
      $display("FAIL np_drop: got %h expected %h", {gnt_o, m0_ack_o}, {2'b10, 1'b0});
    else passed++;
    tick();
    s_ack_i = 1'b1; s_data_i = 32'h3333_0000;
    sb.push_back('{m: 2'b01, err: 1'b0, data: s_data_i});
    @(negedge clk);
    checks++;
    if ({gnt_o, s_addr_o} !== {2'b01, 18'h20020})
      $display("FAIL np_handover: got %h expected %h", {gnt_o, s_addr_o}, {2'b01, 18'h20020});
    else passed++;
    o = obs_now(); e = sb_pop();
    checks++;
    if (o !== e) $display("FAIL np_m0_resp: got %h expected %h", o, e);
    else passed++;
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 18'h0, 32'h0);
    tick();
  endtask

  task automatic test_timeout(input int m);
    resp_t e, o;
    logic [1:0] oh = (m == 0) ? 2'b01 : 2'b10;
    tick();
    drive_m(m, 1, 1, 0, (m == 0) ? 18'h2000C : 18'h0000C, 32'h0);
    sb.push_back('{m: oh, err: 1'b1, data: 32'h0});
    @(negedge clk);
    tick();
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      @(negedge clk);
      checks++;
      if ({gnt_o, s_cyc_o, err_of(m)} !== {oh, 1'b1, 1'b0})
        $display("FAIL to_stall_%0d: got %h expected %h", k, {gnt_o, s_cyc_o, err_of(m)}, {oh, 1'b1, 1'b0});
      else passed++;
      tick();
    end
    @(negedge clk);
    o = obs_now(); e = sb_pop();
    checks++;
    if (o !== e) $display("FAIL to_err_resp: got %h expected %h", o, e);
    else passed++;
    checks++;
    if ({gnt_o, s_cyc_o, s_stb_o} !== {oh, 2'b00})
      $display("FAIL to_term_bus: got %h expected %h", {gnt_o, s_cyc_o, s_stb_o}, {oh, 2'b00});
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, err_of(m), s_cyc_o} !== {oh, 2'b00})
      $display("FAIL to_err_once: got %h expected %h", {gnt_o, err_of(m), s_cyc_o}, {oh, 2'b00});
    else passed++;
    tick();
    drive_m(m, 0, 0, 0, 18'h0, 32'h0);
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) $display("FAIL to_idle: got %b expected %b", gnt_o, 2'b00);
    else passed++;
  endtask

  task automatic test_ack_terminal(input int m);
    resp_t e, o;
    logic [1:0] oh = (m == 0) ? 2'b01 : 2'b10;
    tick();
    drive_m(m, 1, 1, 0, (m == 0) ? 18'h20018 : 18'h00018, 32'h0);
    @(negedge clk);
    tick();
    for (int k = 0; k < int'(TIMEOUT) - 1; k++) begin
      @(negedge clk);
      checks++;
      if ({ack_of(m), err_of(m)} !== 2'b00)
        $display("FAIL at_stall_%0d: got %b expected %b", k, {ack_of(m), err_of(m)}, 2'b00);
      else passed++;
      tick();
    end
    s_ack_i = 1'b1; s_data_i = 32'hACED_0000 + 32'(m);
    sb.push_back('{m: oh, err: 1'b0, data: s_data_i});
    @(negedge clk);
    o = obs_now(); e = sb_pop();
    checks++;
    if (o !== e) $display("FAIL at_resp: got %h expected %h", o, e);
    else passed++;
    tick();
    s_ack_i = 1'b0;
    drive_m(m, 0, 0, 0, 18'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({gnt_o, err_of(m)} !== {oh, 1'b0})
      $display("FAIL at_no_err: got %h expected %h", {gnt_o, err_of(m)}, {oh, 1'b0});
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, err_of(m)} !== 3'b000)
      $display("FAIL at_idle: got %h expected %h", {gnt_o, err_of(m)}, 3'b000);
    else passed++;
  endtask

  task automatic test_reset_mid();
    resp_t e, o;
    tick();
    drive_m(1, 1, 1, 1, 18'h00080, 32'h5A5A_5A5A);
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if ({gnt_o, s_cyc_o} !== {2'b10, 1'b1})
      $display("FAIL rm_owned: got %h expected %h", {gnt_o, s_cyc_o}, {2'b10, 1'b1});
    else passed++;
    tick();
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, gnt_o} !== 4'h0)
      $display("FAIL rm_async: got %h expected %h", {s_cyc_o, s_stb_o, gnt_o}, 4'h0);
    else passed++;
    s_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'h0)
      $display("FAIL rm_resp_zero: got %h expected %h", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'h0);
    else passed++;
    s_ack_i = 1'b0;
    drive_m(0, 1, 1, 0, 18'h20030, 32'h0);
    drive_m(1, 1, 1, 0, 18'h00090, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    s_ack_i = 1'b1; s_data_i = 32'h4444_0000;
    sb.push_back('{m: 2'b01, err: 1'b0, data: s_data_i});
    @(negedge clk);
    checks++;
    if ({gnt_o, s_addr_o} !== {2'b01, 18'h20030})
      $display("FAIL rm_first: got %h expected %h", {gnt_o, s_addr_o}, {2'b01, 18'h20030});
    else passed++;
    o = obs_now(); e = sb_pop();
    checks++;
    if (o !== e) $display("FAIL rm_m0_resp: got %h expected %h", o, e);
    else passed++;
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 0, 0, 0, 18'h0, 32'h0);
    tick();
    s_ack_i = 1'b1; s_data_i = 32'h5555_0000;
    sb.push_back('{m: 2'b10, err: 1'b0, data: s_data_i});
    @(negedge clk);
    o = obs_now(); e = sb_pop();
    checks++;
    if ({gnt_o, o} !== {2'b10, e}) $display("FAIL rm_m1_resp: got %h expected %h", {gnt_o, o}, {2'b10, e});
    else passed++;
    tick();
    s_ack_i = 1'b0;
    drive_m(1, 0, 0, 0, 18'h0, 32'h0);
    tick();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) $display("FAIL rm_idle: got %b expected %b", gnt_o, 2'b00);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    nrst = 1'b0;
    s_ack_i = 1'b0;
    s_data_i = 32'h0;
    drive_m(0, 0, 0, 0, 18'h0, 32'h0);
    drive_m(1, 0, 0, 0, 18'h0, 32'h0);
    test_reset();
    test_simultaneous();
    test_single_write();
    test_no_preempt();
    test_timeout(0);
    test_timeout(1);
    test_ack_terminal(0);
    test_ack_terminal(1);
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: got %0d expected %0d", sb.size(), 0);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/usbf_wb_arbiter.md
# usbf_wb_arbiter

Two-master Wishbone arbiter in front of the USB function core's Wishbone slave port, which holds the register file and endpoint buffer memory. It shares that port between the function controller (master 0) and a second requester (master 1, the audio sample mover that fills and drains endpoint buffers). Arbitration is round-robin per Wishbone cycle (`cyc` held). A stall watchdog terminates any access the core never acknowledges, so neither master can lock the port.

## Interface
- `ADDR_W`, 18: Wishbone address width, equal to `USBF_UFC_HADR`+1. MSB=1 selects the register file, MSB=0 selects buffer memory.
- `TIMEOUT`, 255: number of stalled cycles (`stb` high, `ack` low) before the access is terminated. Legal range 2..65535.
- `clk_i` in 1: single clock, all logic on the rising edge.
- `nrst_i` in 1: asynchronous, active-low reset.
- `m0_addr_i` in ADDR_W, `m0_data_i` in 32, `m0_we_i` in 1, `m0_stb_i` in 1, `m0_cyc_i` in 1: master 0 request.
- `m0_data_o` out 32, `m0_ack_o` out 1, `m0_err_o` out 1: master 0 response.
- `m1_*`: same set of ports as master 0, for master 1.
- `s_addr_o` out ADDR_W, `s_data_o` out 32, `s_we_o` out 1, `s_stb_o` out 1, `s_cyc_o` out 1: to the USB core slave.
- `s_data_i` in 32, `s_ack_i` in 1: from the USB core slave.
- `gnt_o` out 2: one-hot current owner. 01 = m0, 10 = m1, 00 = none.

## Operation
- State machine states: IDLE, GNT0, GNT1, TERM0, TERM1. Register `last` holds the last master granted; reset value is 1.
- **IDLE**
  - Only `mX_cyc_i` high → GNTX next cycle.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- **GNTX**
  - `s_addr_o`, `s_data_o`, `s_we_o`, `s_stb_o` and `s_cyc_o` are driven combinationally from master X.
  - `mX_ack_o` = `s_ack_i`. The other master's ack is 0.
  - Set `last`=X on entry.
- **Leaving GNTX**
  - Ownership is held while `mX_cyc_i` stays high, across any number of `stb` beats. There is no preemption.
  - When `mX_cyc_i` is sampled low: go to GNT(other) if the other master's `cyc` is high, with no idle cycle; otherwise go to IDLE.
- **Watchdog**
  - A counter of width clog2(TIMEOUT+1) increments on each GNTX cycle with `s_stb_o`=1 and `s_ack_i`=0.
  - It clears on ack, on any state change, and whenever `stb` is low.
  - When it holds TIMEOUT-1 and the current cycle stalls, the next state is TERMX.
  - If ack and the terminal count occur in the same cycle, ack wins: normal completion, no error.
- **TERMX**
  - `s_stb_o`=`s_cyc_o`=0 and `gnt_o` stays at X.
  - `mX_err_o`=1 for exactly the first TERMX cycle (registered), 0 afterwards.
  - Stay in TERMX until `mX_cyc_i` is low, then arbitrate exactly as on leaving GNTX.
- **Data and idle outputs**
  - `m0_data_o` = `m1_data_o` = `s_data_i` (broadcast). Masters qualify it with their own ack.
  - In IDLE and TERMX, `s_addr_o` and `s_data_o` are 0, and `s_we_o`, `s_stb_o`, `s_cyc_o` are 0.
- **Reset**
  - Asserting `nrst_i` mid-operation immediately forces state IDLE, `last`=1, counter 0, `gnt_o`=00.
  - All `s_*` outputs, acks and errs go to 0. Any in-flight access is abandoned.

## Timing
- Request latency: a master's `cyc` sampled high in an idle cycle N → grant registered, slave strobe visible in cycle N+1.
- Ack path is combinational, zero cycles from `s_ack_i` to `mX_ack_o`.
- Back-to-back handover: the owner's `cyc` sampled low in cycle N → the other master drives the slave in cycle N+1.
- Timeout: with `stb` first high in grant cycle G and no ack, `mX_err_o`=1 in cycle G+TIMEOUT and `s_cyc_o`=0 from that cycle.
- Reset values: all outputs 0; `gnt_o`=00.

## Test plan
- **Single m0 write.** m0 writes addr 0x20004, data 0x0 with m1 idle; slave acks 3 cycles after `stb`. Required: `gnt_o`=01 one cycle after `cyc`; `s_*` mirror m0; `m0_ack_o` one cycle high; `m1_ack_o`=0; back to IDLE after m0 drops `cyc`.
- **Simultaneous requests after reset.** m0 and m1 raise `cyc` together. Required: m0 granted first; m1 granted the cycle after m0's `cyc` is sampled low. On the next simultaneous request m0 is granted again (`last`=1).
- **No preemption.** m1 holds `cyc` for 4 consecutive `stb` beats, each acked, while m0 requests throughout. Required: `gnt_o` stays 10 until m1 drops `cyc`; m0 sees no ack before then.
- **Timeout.** With TIMEOUT=8, m0 reads 0x2000C and the slave never acks. Required: `m0_err_o` pulses once, 8 cycles after grant; `s_cyc_o`=0 from that cycle. Then m0 drops `cyc` → IDLE.
- **Ack at terminal count.** With TIMEOUT=8, the slave acks on the 8th stalled cycle. Required: normal ack, `m0_err_o`=0.
- **Reset mid-transaction.** `nrst_i` is pulled low while m1 is mid-transaction. Required: `s_cyc_o`, `s_stb_o` and `gnt_o` go to 0 with no clock edge. After release with both masters requesting, m0 is granted first.
